// File: rtl/os_irq_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : os_irq_ctrl_pkg                                               |
// | Purpose  : Shared types and helpers for the interrupt request controller |
// |            (IPL width, level type, "no interrupt" code, level lookup).   |
// | Ports    : none (package)                                                |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
package os_irq_ctrl_pkg;

  localparam int IPL_W   = 3;
  localparam int MAX_SRC = 8;

  typedef logic [IPL_W-1:0] ipl_t;

  // Encoded IPL pins when nothing is requesting (active-low level 0).
  localparam ipl_t IPL_NONE = 3'b111;

  // Level of source i out of a packed level map (source 0 in the LSBs).
  // The map is widened to the maximum source count by the caller.
  function automatic ipl_t lvl_of(input logic [MAX_SRC*IPL_W-1:0] map, input int i);
    return map[i*IPL_W +: IPL_W];
  endfunction

endpackage : os_irq_ctrl_pkg
`default_nettype wire

// File: rtl/os_irq_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : os_irq_ctrl_if                                                |
// | Purpose  : Bundle of request, control and IPL signals between the pulse  |
// |            generators / CPU wrapper (master) and the controller (slave). |
// | Ports    : src_pulse, src_en, clr, iack, iack_lvl   master -> slave      |
// |            pending, ipl_n, irq                      slave  -> master     |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
interface os_irq_ctrl_if #(
  parameter int NSRC = 4
);
  import os_irq_ctrl_pkg::*;

  logic [NSRC-1:0] src_pulse;
  logic [NSRC-1:0] src_en;
  logic [NSRC-1:0] clr;
  logic            iack;
  ipl_t            iack_lvl;
  logic [NSRC-1:0] pending;
  ipl_t            ipl_n;
  logic            irq;

  modport master (
    output src_pulse, src_en, clr, iack, iack_lvl,
    input  pending, ipl_n, irq
  );

  modport slave (
    input  src_pulse, src_en, clr, iack, iack_lvl,
    output pending, ipl_n, irq
  );

endinterface : os_irq_ctrl_if
`default_nettype wire

// File: rtl/os_irq_ctrl_slot.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : os_irq_slot                                                   |
// | Purpose  : One interrupt source: rising-edge detect on the pulse input,  |
// |            set/clear arbitration and the pending flop.                   |
// | Ports    : clk, reset_n       clock / sync active-low reset              |
// |            i_pulse, i_en      source pulse and enable                    |
// |            i_clr              software clear                             |
// |            i_iack, i_iack_lvl CPU acknowledge strobe and level           |
// |            o_pending          latched request                            |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module os_irq_slot
  import os_irq_ctrl_pkg::*;
#(
  parameter ipl_t LVL = 3'd0
) (
  input  wire  clk,
  input  wire  reset_n,
  input  wire  i_pulse,
  input  wire  i_en,
  input  wire  i_clr,
  input  wire  i_iack,
  input  ipl_t i_iack_lvl,
  output logic o_pending
);

  logic r_prev;
  logic r_pending;
  logic w_edge;
  logic w_ack_hit;
  logic w_pending_nxt;

  assign w_edge    = i_pulse & ~r_prev;
  assign w_ack_hit = i_iack & (i_iack_lvl == LVL);

  // Enable low wins outright; an accepted edge then wins over any release,
  // so a request arriving in the same cycle as its acknowledge is not lost.
  always_comb begin
    w_pending_nxt = r_pending;
    if (!i_en) begin
      w_pending_nxt = 1'b0;
    end else if (w_edge) begin
      w_pending_nxt = 1'b1;
    end else if (i_clr || w_ack_hit) begin
      w_pending_nxt = 1'b0;
    end
  end

  // prev resets high so a pulse already asserted at reset release is ignored.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_prev    <= 1'b1;
      r_pending <= 1'b0;
    end else begin
      r_prev    <= i_pulse;
      r_pending <= w_pending_nxt;
    end
  end

  assign o_pending = r_pending;

endmodule : os_irq_slot
`default_nettype wire

// File: rtl/os_irq_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : os_irq_ctrl                                                   |
// | Purpose  : Latches interrupt strobes per source and drives a registered, |
// |            prioritised active-low interrupt level to the 68000 IPL pins. |
// | Ports    : clk      system clock                                         |
// |            reset_n  synchronous active-low reset                         |
// |            bus      os_irq_ctrl_if.slave (requests in, IPL out)          |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module os_irq_ctrl
  import os_irq_ctrl_pkg::*;
#(
  parameter int                  NSRC    = 4,
  parameter logic [3*NSRC-1:0]   LVL_MAP = 12'o6421
) (
  input  wire          clk,
  input  wire          reset_n,
  os_irq_ctrl_if.slave bus
);

  logic [NSRC-1:0] w_pending;
  ipl_t            w_lvl;
  ipl_t            r_ipl_n;

  for (genvar gi = 0; gi < NSRC; gi++) begin : g_slot
    os_irq_slot #(
      .LVL (lvl_of((MAX_SRC*IPL_W)'(LVL_MAP), gi))
    ) u_slot (
      .clk        (clk),
      .reset_n    (reset_n),
      .i_pulse    (bus.src_pulse[gi]),
      .i_en       (bus.src_en[gi]),
      .i_clr      (bus.clr[gi]),
      .i_iack     (bus.iack),
      .i_iack_lvl (bus.iack_lvl),
      .o_pending  (w_pending[gi])
    );
  end : g_slot

  // Highest level among pending sources; level-0 sources can never exceed
  // the zero start value, so they latch but never request.
  always_comb begin
    w_lvl = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (w_pending[i] && (lvl_of((MAX_SRC*IPL_W)'(LVL_MAP), i) > w_lvl)) begin
        w_lvl = lvl_of((MAX_SRC*IPL_W)'(LVL_MAP), i);
      end
    end
  end

  // Registered so the IPL pins only move on clock edges.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_ipl_n <= IPL_NONE;
    end else begin
      r_ipl_n <= ~w_lvl;
    end
  end

  assign bus.pending = w_pending;
  assign bus.ipl_n   = r_ipl_n;
  assign bus.irq     = (r_ipl_n != IPL_NONE);

endmodule : os_irq_ctrl
`default_nettype wire

// File: tb/tb_os_irq_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_os_irq_ctrl                                                |
// | Purpose  : Directed scoreboard bench for os_irq_ctrl (4 sources, levels  |
// |            1/2/4/6). Stimulus queues the expected pending/IPL state for  |
// |            a target cycle; a monitor compares on the falling edge.       |
// | Ports    : none                                                          |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_os_irq_ctrl;

  typedef struct {
    int         cyc;
    string      nm;
    logic [3:0] p;
    logic [2:0] ipl;
    logic       irq;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n;
  int   cycle_cnt = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb[$];

  os_irq_ctrl_if #(.NSRC(4)) bus ();

  os_irq_ctrl #(
    .NSRC    (4),
    .LVL_MAP (12'o6421)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  // Expected outputs d clock edges from now; irq follows from the IPL code.
  task automatic expect_in(input int d, input string nm, input logic [3:0] p, input logic [2:0] ipl);
    exp_t e;
    e.cyc = cycle_cnt + d;
    e.nm  = nm;
    e.p   = p;
    e.ipl = ipl;
    e.irq = (ipl != 3'b111);
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare every queued entry whose target cycle has arrived.
  always @(negedge clk) begin
    for (int k = sb.size() - 1; k >= 0; k--) begin
      if (sb[k].cyc == cycle_cnt) begin
        n_cmp++;
        if ({bus.pending, bus.ipl_n, bus.irq} !== {sb[k].p, sb[k].ipl, sb[k].irq}) begin
          n_err++;
          $display("FAIL %s: got pending=%h ipl_n=%b irq=%b, want pending=%h ipl_n=%b irq=%b",
                   sb[k].nm, bus.pending, bus.ipl_n, bus.irq, sb[k].p, sb[k].ipl, sb[k].irq);
        end
        sb.delete(k);
      end else if (sb[k].cyc < cycle_cnt) begin
        n_cmp++;
        n_err++;
        $display("FAIL %s: entry for cycle %0d not checked by cycle %0d", sb[k].nm, sb[k].cyc, cycle_cnt);
        sb.delete(k);
      end
    end
  end

  initial begin
    reset_n      = 1'b0;
    bus.src_pulse = 4'hF;
    bus.src_en   = 4'h0;
    bus.clr      = 4'h0;
    bus.iack     = 1'b0;
    bus.iack_lvl = 3'd0;

    // Reset held with pulses high.
    step(); step(); step();
    expect_in(0, "reset", 4'h0, 3'b111);

    // Release with pulses still high: no edge, no request.
    reset_n = 1'b1; bus.src_en = 4'hF;
    expect_in(1, "rel_no_req", 4'h0, 3'b111); step();
    bus.src_pulse = 4'h0; bus.src_en = 4'h1;
    expect_in(1, "rel_no_req2", 4'h0, 3'b111); step();

    // Single source: held 3-cycle pulse on src 0 sets once.
    bus.src_pulse = 4'h1;
    expect_in(1, "single_set", 4'h1, 3'b111); step();
    bus.clr = 4'h1;
    expect_in(1, "single_ipl", 4'h0, 3'b110); step();
    bus.clr = 4'h0;
    expect_in(1, "held_no_reset", 4'h0, 3'b111); step();
    bus.src_pulse = 4'h0;
    expect_in(1, "held_release", 4'h0, 3'b111); step();

    // Priority between level 1 and level 4, then acknowledge level 4.
    bus.src_en = 4'hF; bus.src_pulse = 4'h5;
    expect_in(1, "prio_set", 4'h5, 3'b111); step();
    bus.src_pulse = 4'h0;
    expect_in(1, "prio_ipl", 4'h5, 3'b011); step();
    bus.iack = 1'b1; bus.iack_lvl = 3'd4;
    expect_in(1, "iack_pend", 4'h1, 3'b011); step();
    bus.iack = 1'b0;
    expect_in(1, "iack_ipl", 4'h1, 3'b110); step();

    // Edge on src 3 collides with an acknowledge of its own level.
    bus.src_pulse = 4'h8; bus.iack = 1'b1; bus.iack_lvl = 3'd6;
    expect_in(1, "coll_pend", 4'h9, 3'b110); step();
    bus.src_pulse = 4'h0; bus.iack_lvl = 3'd5;
    expect_in(1, "coll_ipl_nomatch", 4'h9, 3'b001); step();
    bus.iack = 1'b0; bus.clr = 4'h9;
    expect_in(1, "clr_all", 4'h0, 3'b001); step();
    bus.clr = 4'h0;
    expect_in(1, "clr_all_ipl", 4'h0, 3'b111); step();

    // Enable-as-clear on src 1, then an edge while disabled is dropped.
    bus.src_pulse = 4'h2;
    expect_in(1, "en_set", 4'h2, 3'b111); step();
    bus.src_pulse = 4'h0;
    expect_in(1, "en_ipl", 4'h2, 3'b101); step();
    bus.src_en = 4'hD;
    expect_in(1, "dis_pend", 4'h0, 3'b101); step();
    bus.src_pulse = 4'h2;
    expect_in(1, "dis_irq", 4'h0, 3'b111); step();
    bus.src_en = 4'hF;
    expect_in(1, "reen_none", 4'h0, 3'b111); step();
    bus.src_pulse = 4'h0;
    expect_in(1, "reen_none2", 4'h0, 3'b111); step();

    // Software clear on src 2.
    bus.src_pulse = 4'h4;
    expect_in(1, "sw_set", 4'h4, 3'b111); step();
    bus.src_pulse = 4'h0;
    expect_in(1, "sw_ipl", 4'h4, 3'b011); step();
    bus.clr = 4'h4;
    expect_in(1, "sw_clr", 4'h0, 3'b011);
    expect_in(2, "sw_ipl_off", 4'h0, 3'b111); step();
    bus.clr = 4'h0; step();

    // Edge and clear in the same cycle: edge wins.
    bus.src_pulse = 4'h4; bus.clr = 4'h4;
    expect_in(1, "edge_beats_clr", 4'h4, 3'b111); step();
    bus.src_pulse = 4'h0; bus.clr = 4'h0;
    expect_in(1, "ebc_ipl", 4'h4, 3'b011); step();

    // Reset mid-operation with every pulse rising.
    reset_n = 1'b0; bus.src_pulse = 4'hF;
    expect_in(1, "rst_mid", 4'h0, 3'b111); step();
    reset_n = 1'b1;
    expect_in(1, "rst_rel", 4'h0, 3'b111); step();
    bus.src_pulse = 4'h0;
    expect_in(1, "rst_after", 4'h0, 3'b111); step();

    for (int w = 0; w < 20 && sb.size() != 0; w++) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain: %0d entries left, want 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_os_irq_ctrl
`default_nettype wire
